// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, frame constants and baud dividers.
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;
    localparam int UART_DATA_BITS = 8;
    localparam int UART_TICKS_PER_BIT = 16;
    // 16x oversampling divide counts from the 100 MHz system clock
    localparam int DEVIDE_CNT_9600 = 651;
    localparam int DEVIDE_CNT_19200 = 326;
    localparam int DEVIDE_CNT_57600 = 109;
    localparam int DEVIDE_CNT_115200 = 54;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: single-clock byte FIFO with registered occupancy counter.
module uart_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [7:0]                 wr_data,
    input  logic                       rd_en,
    output logic [7:0]                 rd_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q, level_d;
    logic          wr_ok, rd_ok;
    assign full    = level_q == (AW+1)'(DEPTH);
    assign empty   = level_q == '0;
    assign level   = level_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    always_comb level_d = level_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
        end
    end
endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-buffered 8N1 transmitter timed by a 16x baud enable.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH    = 16,
    parameter int TICKS_PER_BIT = UART_TICKS_PER_BIT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clken_16bps,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          busy,
    output logic                          tx_done,
    output logic                          fpga_txd
);
    localparam int TW = $clog2(TICKS_PER_BIT + 1);
    localparam int BW = $clog2(UART_DATA_BITS);
    uart_state_e   state_q;
    logic [TW-1:0] tick_q;
    logic [BW-1:0] bit_q;
    logic [7:0]    shift_q, rd_data;
    logic          txd_q, busy_q, done_q, ovf_q, empty, pop, tick_end;
    assign pop      = state_q == IDLE && !empty;
    assign tick_end = clken_16bps && tick_q == TW'(TICKS_PER_BIT - 1);
    assign fpga_txd = txd_q;
    assign busy     = busy_q;
    assign tx_done  = done_q;
    assign overflow = ovf_q;
    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (rd_data),
        .level   (level),
        .full    (full),
        .empty   (empty)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (wr_en && full) ovf_q <= 1'b1;
            // bit-end branches below override this increment with a clear
            if (state_q != IDLE && clken_16bps) tick_q <= tick_q + TW'(1);
            case (state_q)
                IDLE: if (pop) begin
                    shift_q <= rd_data;
                    txd_q   <= 1'b0;
                    tick_q  <= '0;
                    busy_q  <= 1'b1;
                    state_q <= START;
                end
                START: if (tick_end) begin
                    txd_q   <= shift_q[0];
                    tick_q  <= '0;
                    bit_q   <= '0;
                    state_q <= DATA;
                end
                DATA: if (tick_end) begin
                    tick_q <= '0;
                    if (bit_q == BW'(UART_DATA_BITS - 1)) begin
                        txd_q   <= 1'b1;
                        state_q <= STOP;
                    end else begin
                        txd_q   <= shift_q[1];
                        shift_q <= shift_q >> 1;
                        bit_q   <= bit_q + BW'(1);
                    end
                end
                STOP: if (tick_end) begin
                    tick_q  <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: directed scenario tests for the buffered UART transmitter.
module tb_uart_tx_buffered;
    logic       clk = 1'b0, rst = 1'b1, wr_en = 1'b0, stall = 1'b0, clken;
    logic [7:0] wr_data = 8'h00;
    logic [1:0] div = 2'd0;
    logic       full, overflow, busy, tx_done, fpga_txd;
    logic [4:0] level;
    int         n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) div <= div + 2'd1;
    assign clken = (div == 2'd3) && !stall;

    uart_tx_buffered #(.FIFO_DEPTH(16), .TICKS_PER_BIT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .clken_16bps (clken),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .full        (full),
        .level       (level),
        .overflow    (overflow),
        .busy        (busy),
        .tx_done     (tx_done),
        .fpga_txd    (fpga_txd)
    );

    task automatic run_len(input logic lvl, output int n);
        n = 0;
        while (fpga_txd === lvl && n < 5000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_low(output bit ok);
        int t = 0;
        while (fpga_txd !== 1'b0 && t < 3000) begin
            t++;
            @(negedge clk);
        end
        ok = fpga_txd === 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        int t = 0;
        while (tx_done !== 1'b1 && t < 200) begin
            t++;
            @(negedge clk);
        end
        ok = tx_done === 1'b1;
    endtask

    // samples mid-bit assuming the call is made near the start-bit edge
    task automatic recv(output logic [7:0] b, output bit ok);
        bit s, d;
        wait_low(s);
        repeat (32) @(negedge clk);
        ok = s && fpga_txd === 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (64) @(negedge clk);
            b[i] = fpga_txd;
        end
        repeat (64) @(negedge clk);
        ok = ok && fpga_txd === 1'b1;
        wait_done(d);
        ok = ok && d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (fpga_txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b want 1", fpga_txd); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
        n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (tx_done !== 1'b0) begin n_fail++; $display("FAIL reset_tx_done: got %b want 0", tx_done); end
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_single_byte();
        int n, extra_done, extra_low;
        bit ok;
        wr_en = 1'b1; wr_data = 8'h41;
        @(negedge clk);
        wr_en = 1'b0;
        n_checks++; if (level !== 5'd1 || fpga_txd !== 1'b1) begin n_fail++; $display("FAIL single_after_write: level %0d txd %b want 1 1", level, fpga_txd); end
        @(negedge clk);
        n_checks++; if (fpga_txd !== 1'b0 || level !== 5'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL single_after_pop: txd %b level %0d busy %b want 0 0 1", fpga_txd, level, busy); end
        run_len(1'b0, n);
        n_checks++; if (n < 61 || n > 64) begin n_fail++; $display("FAIL single_start_len: got %0d want 61..64", n); end
        run_len(1'b1, n);
        n_checks++; if (n != 64) begin n_fail++; $display("FAIL single_bit0_len: got %0d want 64", n); end
        run_len(1'b0, n);
        n_checks++; if (n != 320) begin n_fail++; $display("FAIL single_bits1_5_len: got %0d want 320", n); end
        run_len(1'b1, n);
        n_checks++; if (n != 64) begin n_fail++; $display("FAIL single_bit6_len: got %0d want 64", n); end
        run_len(1'b0, n);
        n_checks++; if (n != 64) begin n_fail++; $display("FAIL single_bit7_len: got %0d want 64", n); end
        wait_done(ok);
        n_checks++; if (!ok || busy !== 1'b0) begin n_fail++; $display("FAIL single_done: done_seen %b busy %b want 1 0", ok, busy); end
        extra_done = 0; extra_low = 0;
        repeat (300) begin
            @(negedge clk);
            if (tx_done === 1'b1) extra_done++;
            if (fpga_txd !== 1'b1) extra_low++;
        end
        n_checks++; if (extra_done != 0 || extra_low != 0) begin n_fail++; $display("FAIL single_quiet: extra_done %0d low_cycles %0d want 0 0", extra_done, extra_low); end
    endtask

    task automatic test_burst();
        logic [7:0] b;
        bit ok;
        int g;
        wr_en = 1'b1; wr_data = 8'h46;
        @(negedge clk);
        n_checks++; if (level !== 5'd1) begin n_fail++; $display("FAIL burst_level_w1: got %0d want 1", level); end
        wr_data = 8'h4E;
        @(negedge clk);
        n_checks++; if (level !== 5'd1) begin n_fail++; $display("FAIL burst_level_w2: got %0d want 1", level); end
        wr_data = 8'h44;
        @(negedge clk);
        wr_en = 1'b0;
        n_checks++; if (level !== 5'd2) begin n_fail++; $display("FAIL burst_level_w3: got %0d want 2", level); end
        recv(b, ok);
        n_checks++; if (!ok || b !== 8'h46) begin n_fail++; $display("FAIL burst_frame0: got %h ok %b want 46 1", b, ok); end
        run_len(1'b1, g);
        n_checks++; if (g < 1 || g > 3 || level !== 5'd1) begin n_fail++; $display("FAIL burst_gap0: gap %0d level %0d want 1..3 1", g, level); end
        recv(b, ok);
        n_checks++; if (!ok || b !== 8'h4E) begin n_fail++; $display("FAIL burst_frame1: got %h ok %b want 4e 1", b, ok); end
        run_len(1'b1, g);
        n_checks++; if (g < 1 || g > 3 || level !== 5'd0) begin n_fail++; $display("FAIL burst_gap1: gap %0d level %0d want 1..3 0", g, level); end
        recv(b, ok);
        n_checks++; if (!ok || b !== 8'h44) begin n_fail++; $display("FAIL burst_frame2: got %h ok %b want 44 1", b, ok); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || level !== 5'd0) begin n_fail++; $display("FAIL burst_idle: busy %b level %0d want 0 0", busy, level); end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_same_cycle();
        logic [7:0] b;
        bit ok;
        wr_en = 1'b1; wr_data = 8'h3C;
        @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);
        wr_en = 1'b1; wr_data = 8'hC3;
        @(negedge clk);
        wr_en = 1'b0;
        recv(b, ok);
        n_checks++; if (!ok || b !== 8'h3C) begin n_fail++; $display("FAIL same_frame_x: got %h ok %b want 3c 1", b, ok); end
        wr_en = 1'b1; wr_data = 8'h5A;
        @(negedge clk);
        wr_en = 1'b0;
        n_checks++; if (level !== 5'd1 || busy !== 1'b1) begin n_fail++; $display("FAIL same_level: level %0d busy %b want 1 1", level, busy); end
        recv(b, ok);
        n_checks++; if (!ok || b !== 8'hC3) begin n_fail++; $display("FAIL same_frame_y: got %h ok %b want c3 1", b, ok); end
        recv(b, ok);
        n_checks++; if (!ok || b !== 8'h5A) begin n_fail++; $display("FAIL same_frame_z: got %h ok %b want 5a 1", b, ok); end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_fill_overflow();
        logic [7:0] b;
        bit ok;
        int nlow;
        for (int i = 0; i < 18; i++) begin
            wr_en = 1'b1; wr_data = 8'h60 + 8'(i);
            @(negedge clk);
            if (i == 0) begin
                n_checks++; if (level !== 5'd1 || busy !== 1'b0) begin n_fail++; $display("FAIL fill_w0: level %0d busy %b want 1 0", level, busy); end
            end else if (i == 1) begin
                n_checks++; if (level !== 5'd1 || busy !== 1'b1) begin n_fail++; $display("FAIL fill_first_pop: level %0d busy %b want 1 1", level, busy); end
            end else if (i == 15) begin
                n_checks++; if (full !== 1'b0 || level !== 5'd15) begin n_fail++; $display("FAIL fill_w15: full %b level %0d want 0 15", full, level); end
            end else if (i == 16) begin
                n_checks++; if (full !== 1'b1 || level !== 5'd16 || overflow !== 1'b0) begin n_fail++; $display("FAIL fill_full: full %b level %0d ovf %b want 1 16 0", full, level, overflow); end
            end else if (i == 17) begin
                n_checks++; if (overflow !== 1'b1 || level !== 5'd16) begin n_fail++; $display("FAIL fill_overflow: ovf %b level %0d want 1 16", overflow, level); end
            end
        end
        wr_en = 1'b0;
        for (int k = 0; k < 17; k++) begin
            recv(b, ok);
            n_checks++; if (!ok || b !== 8'h60 + 8'(k)) begin n_fail++; $display("FAIL fill_frame%0d: got %h ok %b want %h 1", k, b, ok, 8'h60 + 8'(k)); end
        end
        nlow = 0;
        repeat (800) begin
            @(negedge clk);
            if (fpga_txd !== 1'b1) nlow++;
        end
        n_checks++; if (nlow != 0 || level !== 5'd0 || busy !== 1'b0 || overflow !== 1'b1) begin n_fail++; $display("FAIL fill_end: low %0d level %0d busy %b ovf %b want 0 0 0 1", nlow, level, busy, overflow); end
    endtask

    task automatic test_reset_mid();
        int nlow, ndone;
        wr_en = 1'b1; wr_data = 8'hA5;
        @(negedge clk);
        wr_data = 8'h11;
        @(negedge clk);
        wr_data = 8'h22;
        @(negedge clk);
        wr_en = 1'b0;
        n_checks++; if (level !== 5'd2) begin n_fail++; $display("FAIL rstmid_level: got %0d want 2", level); end
        repeat (280) @(negedge clk);
        n_checks++; if (fpga_txd !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_bit3: txd %b busy %b want 0 1", fpga_txd, busy); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (fpga_txd !== 1'b1 || level !== 5'd0 || busy !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL rstmid_after: txd %b level %0d busy %b ovf %b want 1 0 0 0", fpga_txd, level, busy, overflow); end
        rst = 1'b0;
        nlow = 0; ndone = 0;
        repeat (2000) begin
            @(negedge clk);
            if (fpga_txd !== 1'b1) nlow++;
            if (tx_done === 1'b1) ndone++;
        end
        n_checks++; if (nlow != 0 || ndone != 0) begin n_fail++; $display("FAIL rstmid_quiet: low %0d done %0d want 0 0", nlow, ndone); end
    endtask

    task automatic test_stall();
        int n, hi, rest, chg;
        bit ok;
        wr_en = 1'b1; wr_data = 8'h01;
        @(negedge clk);
        wr_en = 1'b0;
        wait_low(ok);
        run_len(1'b0, n);
        hi = 1;
        repeat (20) begin
            @(negedge clk);
            if (fpga_txd === 1'b1) hi++;
        end
        stall = 1'b1;
        chg = 0;
        repeat (1000) begin
            @(negedge clk);
            if (fpga_txd !== 1'b1) chg++; else hi++;
        end
        stall = 1'b0;
        n_checks++; if (chg != 0) begin n_fail++; $display("FAIL stall_hold: changed %0d want 0", chg); end
        run_len(1'b1, rest);
        n_checks++; if (hi + rest - 1 != 1064) begin n_fail++; $display("FAIL stall_bit0_len: got %0d want 1064", hi + rest - 1); end
        run_len(1'b0, n);
        n_checks++; if (n != 448) begin n_fail++; $display("FAIL stall_bits1_7_len: got %0d want 448", n); end
        wait_done(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL stall_done: seen %b want 1", ok); end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_byte();
        test_burst();
        test_same_cycle();
        test_fill_overflow();
        test_reset_mid();
        test_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
